coralnpu_irq_ctrl: RTL

Parametrised interrupt controller between the testbench/SoC interrupt sources and the core's single `irq` input. It aggregates `NUM_SRC` sources, each individually enabled and configured as level or rising-edge. It tracks pending and in-service state per source, and arbitrates by fixed priority (lowest index wins) through a claim/complete handshake. It also uses the core status signals `halted` and `wfi` to mask the interrupt and to generate a wake pulse.

---
 rtl/coralnpu_irq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/coralnpu_irq_ctrl.sv
// rtl/coralnpu_irq_ctrl.sv - fixed-priority interrupt controller with claim/complete handshake
module coralnpu_irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 8,
  localparam int ID_W   = $clog2(NUM_SRC + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic [NUM_SRC-1:0] src_edge,
  input  logic               halted,
  input  logic               wfi,
  output logic               irq,
  output logic               wake,
  input  logic               claim_req,
  output logic               claim_ack,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service,
  output logic [CNT_W-1:0]   coalesced_cnt,
  input  logic               cnt_clr
);

  localparam logic [CNT_W+5:0] CNT_MAX = {6'd0, {CNT_W{1'b1}}};

  logic [NUM_SRC-1:0] src_q_q, src_q_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic               irq_q, irq_d;
  logic               wake_q, wake_d;
  logic               claim_ack_q, claim_ack_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] claim_vec;
  logic [ID_W-1:0]    claim_sel;
  logic               found;
  logic [5:0]         inc_cnt;
  logic [CNT_W+5:0]   cnt_sum;

  // Next-state logic: edge detect, pending/in-service update, claim arbitration, coalescing count
  always_comb begin
    src_q_d      = src;
    rise         = src & ~src_q_q;
    eligible     = pending_q & ~in_service_q & src_en;
    claim_vec    = '0;
    claim_sel    = '0;
    found        = 1'b0;
    inc_cnt      = 6'd0;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    cnt_sum      = '0;
    cnt_d        = cnt_q;

    // Lowest eligible index wins; only when a claim is actually requested.
    if (claim_req) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (eligible[i] && !found) begin
          found        = 1'b1;
          claim_vec[i] = 1'b1;
          claim_sel    = ID_W'(i + 1);
        end
      end
    end

    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_edge[i]) begin
        // A new edge beats a simultaneous claim-clear so that edge is not lost.
        pending_d[i] = (rise[i] & src_en[i]) | (pending_q[i] & ~claim_vec[i]);
        if (rise[i] && src_en[i] && pending_q[i] && !claim_vec[i]) begin
          inc_cnt = inc_cnt + 6'd1;
        end
      end else begin
        pending_d[i] = src[i] & src_en[i];
      end
      // Out-of-range or zero IDs never match, so they fall through as no-ops.
      if (complete_valid && complete_id == ID_W'(i + 1)) begin
        in_service_d[i] = 1'b0;
      end
    end
    in_service_d = in_service_d | claim_vec;

    if (cnt_clr) begin
      cnt_d = '0;
    end else begin
      cnt_sum = {6'd0, cnt_q} + {{CNT_W{1'b0}}, inc_cnt};
      cnt_d   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    irq_d       = (|eligible) & ~halted;
    wake_d      = irq_d & ~irq_q & wfi;
    claim_ack_d = claim_req;
    claim_id_d  = claim_req ? claim_sel : claim_id_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q_q      <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_q        <= 1'b0;
      wake_q       <= 1'b0;
      claim_ack_q  <= 1'b0;
      claim_id_q   <= '0;
      cnt_q        <= '0;
    end else begin
      src_q_q      <= src_q_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_q        <= irq_d;
      wake_q       <= wake_d;
      claim_ack_q  <= claim_ack_d;
      claim_id_q   <= claim_id_d;
      cnt_q        <= cnt_d;
    end
  end

  assign irq           = irq_q;
  assign wake          = wake_q;
  assign claim_ack     = claim_ack_q;
  assign claim_id      = claim_id_q;
  assign pending       = pending_q;
  assign in_service    = in_service_q;
  assign coalesced_cnt = cnt_q;

endmodule
